// File: rtl/dino_score_keeper_if.sv
// Bundle between the game controller, the score keeper and the display/motion stages.
// The master drives the game strobes; the slave (score keeper) drives scores and speed.
interface dino_score_keeper_if;
  logic        tick;
  logic        is_living;
  logic        frame_start;
  logic [3:0]  move_rate;
  logic [19:0] score_disp;
  logic [19:0] hi_disp;
  logic        milestone;
  logic        score_flash;

  modport master (
    output tick, is_living, frame_start,
    input  move_rate, score_disp, hi_disp, milestone, score_flash
  );

  modport slave (
    input  tick, is_living, frame_start,
    output move_rate, score_disp, hi_disp, milestone, score_flash
  );
endinterface

// File: rtl/dino_score_keeper.sv
// Dino game score/difficulty engine: 5-digit BCD score, sticky high score,
// speed-up every 100 points, and per-frame snapshots for the score renderer.
module dino_score_keeper #(
  parameter int         TICK_DIV     = 10,
  parameter logic [3:0] RATE_BASE    = 4'd2,
  parameter logic [3:0] RATE_MAX     = 4'd10,
  parameter int         FLASH_FRAMES = 30
) (
  input  logic               lcd_pclk,
  input  logic               rst_n,
  dino_score_keeper_if.slave bus
);

  localparam int              DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              FL_W      = $clog2(FLASH_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [FL_W-1:0] FL_LOAD   = FL_W'(FLASH_FRAMES);
  localparam logic [19:0]     SCORE_MAX = 20'h99999;

  logic             live_q;
  logic [DIV_W-1:0] div_q;
  logic [19:0]      score;
  logic [19:0]      hi_score;
  logic [FL_W-1:0]  flash_cnt;
  logic [3:0]       move_rate_q;
  logic [19:0]      score_disp_q;
  logic [19:0]      hi_disp_q;
  logic             milestone_q;

  logic        start;
  logic        death;
  logic        count_en;
  logic        wrap;
  logic        bump;
  logic [19:0] score_inc;
  logic        hit_milestone;

  function automatic logic [19:0] bcd_inc(input logic [19:0] v);
    logic [19:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A start edge wins over a coincident tick; 99999 blocks both the bump and the milestone.
  always_comb begin
    start         = bus.is_living & ~live_q;
    death         = ~bus.is_living & live_q;
    count_en      = bus.tick & bus.is_living & ~start;
    wrap          = count_en && (div_q == DIV_LAST);
    bump          = wrap && (score != SCORE_MAX);
    score_inc     = bcd_inc(score);
    hit_milestone = bump && (score_inc[7:0] == 8'h00);
  end

  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      div_q    <= '0;
      score    <= '0;
      hi_score <= '0;
    end else begin
      live_q <= bus.is_living;
      if (start) begin
        score <= '0;
        div_q <= '0;
      end else if (count_en) begin
        div_q <= wrap ? '0 : div_q + DIV_W'(1);
        if (bump) score <= score_inc;
      end
      // BCD words order the same as their decimal values, so a plain compare works.
      if (death && (score > hi_score)) hi_score <= score;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      move_rate_q <= RATE_BASE;
      flash_cnt   <= '0;
      milestone_q <= 1'b0;
    end else begin
      milestone_q <= hit_milestone;
      if (start) begin
        move_rate_q <= RATE_BASE;
        flash_cnt   <= '0;
      end else if (hit_milestone) begin
        move_rate_q <= (move_rate_q < RATE_MAX) ? move_rate_q + 4'd1 : RATE_MAX;
        flash_cnt   <= FL_LOAD;
      end else if (bus.frame_start && (flash_cnt != '0)) begin
        flash_cnt <= flash_cnt - FL_W'(1);
      end
    end
  end

  // Snapshots take the registered values, so same-cycle updates show next frame.
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      score_disp_q <= '0;
      hi_disp_q    <= '0;
    end else if (bus.frame_start) begin
      score_disp_q <= score;
      hi_disp_q    <= hi_score;
    end
  end

  assign bus.move_rate   = move_rate_q;
  assign bus.score_disp  = score_disp_q;
  assign bus.hi_disp     = hi_disp_q;
  assign bus.milestone   = milestone_q;
  assign bus.score_flash = (flash_cnt != '0);

endmodule

// File: tb/tb_dino_score_keeper.sv
// Directed bench for dino_score_keeper: counting, milestones, flash, high score,
// edge cases around is_living transitions, saturation and mid-run reset.
module tb_dino_score_keeper;

  logic lcd_pclk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  dino_score_keeper_if bus ();

  dino_score_keeper #(
    .TICK_DIV    (10),
    .RATE_BASE   (4'd2),
    .RATE_MAX    (4'd10),
    .FLASH_FRAMES(30)
  ) dut (
    .lcd_pclk(lcd_pclk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  // Inputs change on the falling edge; outputs are read there too.
  task automatic run_ticks(input int n, output int ms);
    ms = 0;
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      @(negedge lcd_pclk);
      if (bus.milestone === 1'b1) ms++;
    end
    bus.tick = 1'b0;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    @(negedge lcd_pclk);
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    int ms;
    rst_n           = 1'b0;
    bus.is_living   = 1'b1;
    bus.tick        = 1'b0;
    bus.frame_start = 1'b0;
    repeat (2) @(negedge lcd_pclk);
    n_checks++; if (bus.move_rate !== 4'd2) begin n_fail++; $display("[TB] FAIL reset_move_rate got=%0d exp=2", bus.move_rate); end
    n_checks++; if (bus.score_disp !== 20'h0) begin n_fail++; $display("[TB] FAIL reset_score_disp got=%h exp=00000", bus.score_disp); end
    n_checks++; if (bus.hi_disp !== 20'h0) begin n_fail++; $display("[TB] FAIL reset_hi_disp got=%h exp=00000", bus.hi_disp); end
    n_checks++; if (bus.milestone !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_milestone got=%b exp=0", bus.milestone); end
    n_checks++; if (bus.score_flash !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flash got=%b exp=0", bus.score_flash); end
    rst_n = 1'b1;
    @(negedge lcd_pclk);
    run_ticks(10, ms);
    frame();
    n_checks++; if (bus.score_disp !== 20'h00001) begin n_fail++; $display("[TB] FAIL first_point score_disp got=%h exp=00001", bus.score_disp); end
    n_checks++; if (bus.move_rate !== 4'd2) begin n_fail++; $display("[TB] FAIL first_point move_rate got=%0d exp=2", bus.move_rate); end
  endtask

  task automatic test_milestone();
    int ms;
    int hi_frames;
    run_ticks(980, ms);
    frame();
    n_checks++; if (bus.score_disp !== 20'h00099) begin n_fail++; $display("[TB] FAIL pre_milestone score_disp got=%h exp=00099", bus.score_disp); end
    n_checks++; if (ms !== 0) begin n_fail++; $display("[TB] FAIL pre_milestone pulses got=%0d exp=0", ms); end
    run_ticks(10, ms);
    n_checks++; if (ms !== 1) begin n_fail++; $display("[TB] FAIL milestone_pulses got=%0d exp=1", ms); end
    n_checks++; if (bus.move_rate !== 4'd3) begin n_fail++; $display("[TB] FAIL milestone_move_rate got=%0d exp=3", bus.move_rate); end
    n_checks++; if (bus.score_flash !== 1'b1) begin n_fail++; $display("[TB] FAIL milestone_flash got=%b exp=1", bus.score_flash); end
    hi_frames = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.score_flash === 1'b1) hi_frames++;
      frame();
      if (k == 0) begin
        n_checks++; if (bus.score_disp !== 20'h00100) begin n_fail++; $display("[TB] FAIL milestone_score_disp got=%h exp=00100", bus.score_disp); end
      end
    end
    n_checks++; if (hi_frames !== 30) begin n_fail++; $display("[TB] FAIL flash_frames got=%0d exp=30", hi_frames); end
    n_checks++; if (bus.score_flash !== 1'b0) begin n_fail++; $display("[TB] FAIL flash_expired got=%b exp=0", bus.score_flash); end
  endtask

  task automatic test_high_score();
    int ms;
    run_ticks(24000, ms);
    n_checks++; if (ms !== 24) begin n_fail++; $display("[TB] FAIL run2500_pulses got=%0d exp=24", ms); end
    n_checks++; if (bus.move_rate !== 4'd10) begin n_fail++; $display("[TB] FAIL rate_saturated got=%0d exp=10", bus.move_rate); end
    frame();
    n_checks++; if (bus.score_disp !== 20'h02500) begin n_fail++; $display("[TB] FAIL run2500_score_disp got=%h exp=02500", bus.score_disp); end
    bus.is_living   = 1'b0;
    bus.frame_start = 1'b1;
    @(negedge lcd_pclk);
    bus.frame_start = 1'b0;
    n_checks++; if (bus.hi_disp !== 20'h0) begin n_fail++; $display("[TB] FAIL death_frame_hi_disp got=%h exp=00000", bus.hi_disp); end
    run_ticks(20, ms);
    frame();
    n_checks++; if (bus.hi_disp !== 20'h02500) begin n_fail++; $display("[TB] FAIL hi_after_death got=%h exp=02500", bus.hi_disp); end
    n_checks++; if (bus.score_disp !== 20'h02500) begin n_fail++; $display("[TB] FAIL dead_ticks_score got=%h exp=02500", bus.score_disp); end
    n_checks++; if (bus.move_rate !== 4'd10) begin n_fail++; $display("[TB] FAIL dead_rate_hold got=%0d exp=10", bus.move_rate); end
    bus.is_living = 1'b1;
    @(negedge lcd_pclk);
    n_checks++; if (bus.move_rate !== 4'd2) begin n_fail++; $display("[TB] FAIL restart_move_rate got=%0d exp=2", bus.move_rate); end
    n_checks++; if (bus.score_flash !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_flash got=%b exp=0", bus.score_flash); end
    run_ticks(12000, ms);
    bus.is_living = 1'b0;
    repeat (2) @(negedge lcd_pclk);
    frame();
    n_checks++; if (bus.score_disp !== 20'h01200) begin n_fail++; $display("[TB] FAIL run1200_score_disp got=%h exp=01200", bus.score_disp); end
    n_checks++; if (bus.hi_disp !== 20'h02500) begin n_fail++; $display("[TB] FAIL hi_kept got=%h exp=02500", bus.hi_disp); end
  endtask

  task automatic test_edge_tick();
    int ms;
    bus.is_living = 1'b1;
    @(negedge lcd_pclk);
    run_ticks(19, ms);
    bus.is_living = 1'b0;
    bus.tick      = 1'b1;
    @(negedge lcd_pclk);
    bus.tick = 1'b0;
    run_ticks(7, ms);
    frame();
    n_checks++; if (bus.score_disp !== 20'h00001) begin n_fail++; $display("[TB] FAIL fall_tick_score got=%h exp=00001", bus.score_disp); end
    bus.is_living = 1'b1;
    bus.tick      = 1'b1;
    @(negedge lcd_pclk);
    bus.tick = 1'b0;
    frame();
    n_checks++; if (bus.score_disp !== 20'h00000) begin n_fail++; $display("[TB] FAIL rise_tick_score got=%h exp=00000", bus.score_disp); end
    run_ticks(9, ms);
    bus.tick        = 1'b1;
    bus.frame_start = 1'b1;
    @(negedge lcd_pclk);
    bus.tick        = 1'b0;
    bus.frame_start = 1'b0;
    n_checks++; if (bus.score_disp !== 20'h00000) begin n_fail++; $display("[TB] FAIL frame_with_inc got=%h exp=00000", bus.score_disp); end
    frame();
    n_checks++; if (bus.score_disp !== 20'h00001) begin n_fail++; $display("[TB] FAIL divider_restart got=%h exp=00001", bus.score_disp); end
  endtask

  task automatic test_saturation();
    int ms;
    force dut.score = 20'h99990;
    @(negedge lcd_pclk);
    release dut.score;
    run_ticks(200, ms);
    frame();
    n_checks++; if (bus.score_disp !== 20'h99999) begin n_fail++; $display("[TB] FAIL sat_score got=%h exp=99999", bus.score_disp); end
    n_checks++; if (ms !== 0) begin n_fail++; $display("[TB] FAIL sat_milestones got=%0d exp=0", ms); end
    n_checks++; if (bus.move_rate !== 4'd2) begin n_fail++; $display("[TB] FAIL sat_move_rate got=%0d exp=2", bus.move_rate); end
    bus.is_living = 1'b0;
    repeat (2) @(negedge lcd_pclk);
    frame();
    n_checks++; if (bus.hi_disp !== 20'h99999) begin n_fail++; $display("[TB] FAIL sat_hi got=%h exp=99999", bus.hi_disp); end
  endtask

  task automatic test_reset_midrun();
    int ms;
    bus.is_living = 1'b1;
    @(negedge lcd_pclk);
    run_ticks(1000, ms);
    frame();
    n_checks++; if (bus.score_disp !== 20'h00100) begin n_fail++; $display("[TB] FAIL midrun_score got=%h exp=00100", bus.score_disp); end
    n_checks++; if (bus.move_rate !== 4'd3) begin n_fail++; $display("[TB] FAIL midrun_rate got=%0d exp=3", bus.move_rate); end
    n_checks++; if (bus.score_flash !== 1'b1) begin n_fail++; $display("[TB] FAIL midrun_flash got=%b exp=1", bus.score_flash); end
    rst_n    = 1'b0;
    bus.tick = 1'b1;
    @(negedge lcd_pclk);
    bus.tick = 1'b0;
    n_checks++; if (bus.move_rate !== 4'd2) begin n_fail++; $display("[TB] FAIL rst_mid_rate got=%0d exp=2", bus.move_rate); end
    n_checks++; if (bus.score_disp !== 20'h0) begin n_fail++; $display("[TB] FAIL rst_mid_score got=%h exp=00000", bus.score_disp); end
    n_checks++; if (bus.hi_disp !== 20'h0) begin n_fail++; $display("[TB] FAIL rst_mid_hi got=%h exp=00000", bus.hi_disp); end
    n_checks++; if (bus.milestone !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_milestone got=%b exp=0", bus.milestone); end
    n_checks++; if (bus.score_flash !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_flash got=%b exp=0", bus.score_flash); end
    rst_n = 1'b1;
    @(negedge lcd_pclk);
    frame();
    n_checks++; if (bus.hi_disp !== 20'h0) begin n_fail++; $display("[TB] FAIL hi_cleared got=%h exp=00000", bus.hi_disp); end
  endtask

  initial begin
    test_reset();
    test_milestone();
    test_high_score();
    test_edge_tick();
    test_saturation();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
